// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered execute-stage ALU with valid/ready handshake.
// Logic, arithmetic and compare ops complete in one cycle; shifts iterate
// SHIFT_STEP bit positions per cycle.
module alu_exec_stage #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_sel,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_z,
  output logic        flag_c,
  output logic        flag_v,
  output logic        flag_s,
  output logic        busy
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SRAI = 4'd8;
  localparam logic [3:0] ALU_OR   = 4'd9;
  localparam logic [3:0] ALU_AND  = 4'd10;
  localparam logic [3:0] ALU_PASS = 4'd11;

  localparam logic [5:0] STEP6 = 6'(SHIFT_STEP);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t state, state_nxt;

  logic        accept;
  logic        is_shift;
  logic        alu_c, alu_v;
  logic [31:0] alu_res;
  logic [32:0] sum_add, sum_sub;
  logic signed [31:0] sa, sb;

  logic [31:0] sh_val, sh_next, fill_mask;
  logic [5:0]  sh_rem, sh_k, rem_next;
  logic        sh_left, sh_fill;

  assign in_ready  = rst & ((state == S_IDLE) | ((state == S_DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_SHIFT);
  assign is_shift  = (alu_sel == ALU_SLL) | (alu_sel == ALU_SRL) |
                     (alu_sel == ALU_SRA) | (alu_sel == ALU_SRAI);

  // Single-cycle operations: result plus carry/overflow from the operands.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sa      = $signed(op_a);
    sb      = $signed(op_b);
    sum_add = {1'b0, op_a} + {1'b0, op_b};
    sum_sub = {1'b0, op_a} + {1'b0, ~op_b} + 33'd1;
    case (alu_sel)
      ALU_ADD: begin
        alu_res = sum_add[31:0];
        alu_c   = sum_add[32];
        alu_v   = (op_a[31] == op_b[31]) & (sum_add[31] != op_a[31]);
      end
      ALU_SUB: begin
        alu_res = sum_sub[31:0];
        alu_c   = sum_sub[32];
        alu_v   = (op_a[31] == ~op_b[31]) & (sum_sub[31] != op_a[31]);
      end
      ALU_SLT:  alu_res = {31'd0, (sa < sb)};
      ALU_SLTU: alu_res = {31'd0, (op_a < op_b)};
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_PASS: alu_res = op_b;
      default:  alu_res = '0;
    endcase
  end

  // One iteration of the shifter: move by min(remaining, SHIFT_STEP).
  always_comb begin
    sh_k      = (sh_rem < STEP6) ? sh_rem : STEP6;
    rem_next  = sh_rem - sh_k;
    fill_mask = sh_fill ? ~(32'hFFFF_FFFF >> sh_k) : 32'd0;
    if (sh_left) sh_next = sh_val << sh_k;
    else         sh_next = (sh_val >> sh_k) | fill_mask;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = (is_shift && (op_b[4:0] != 5'd0)) ? S_SHIFT : S_DONE;
    end else begin
      case (state)
        S_SHIFT: if (rem_next == 6'd0) state_nxt = S_DONE;
        S_DONE:  if (out_ready) state_nxt = S_IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Result and flag registers; held whenever nothing new is produced.
  always_ff @(posedge clk) begin
    if (!rst) begin
      result <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      flag_s <= 1'b0;
    end else if (accept) begin
      if (is_shift) begin
        // Zero-distance shift completes immediately; otherwise keep the old result.
        if (op_b[4:0] == 5'd0) begin
          result <= op_a;
          flag_z <= (op_a == 32'd0);
          flag_c <= 1'b0;
          flag_v <= 1'b0;
          flag_s <= op_a[31];
        end
      end else begin
        result <= alu_res;
        flag_z <= (alu_res == 32'd0);
        flag_c <= alu_c;
        flag_v <= alu_v;
        flag_s <= alu_res[31];
      end
    end else if ((state == S_SHIFT) && (rem_next == 6'd0)) begin
      result <= sh_next;
      flag_z <= (sh_next == 32'd0);
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      flag_s <= sh_next[31];
    end
  end

  // Shifter working registers; SRA/SRAI fill with the sign of op_a.
  always_ff @(posedge clk) begin
    if (accept && is_shift) begin
      sh_val  <= op_a;
      sh_rem  <= {1'b0, op_b[4:0]};
      sh_left <= (alu_sel == ALU_SLL);
      sh_fill <= ((alu_sel == ALU_SRA) | (alu_sel == ALU_SRAI)) & op_a[31];
    end else if (state == S_SHIFT) begin
      sh_val <= sh_next;
      sh_rem <= rem_next;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed and randomized checks of alu_exec_stage
// against a plain-arithmetic reference model.
module tb_alu_exec_stage;

  localparam int STEP = 4;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SRAI = 4'd8;
  localparam logic [3:0] ALU_OR   = 4'd9;
  localparam logic [3:0] ALU_AND  = 4'd10;
  localparam logic [3:0] ALU_PASS = 4'd11;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_sel;
  logic [31:0] op_a, op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_z, flag_c, flag_v, flag_s;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_exec_stage #(.SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_sel(alu_sel), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flag_z(flag_z), .flag_c(flag_c),
    .flag_v(flag_v), .flag_s(flag_s), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_shift_op(input logic [3:0] sel);
    return sel == ALU_SLL || sel == ALU_SRL || sel == ALU_SRA || sel == ALU_SRAI;
  endfunction

  // Reference model from the operation definitions, using wide integer math.
  function automatic void model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic c, output logic v);
    longint unsigned ua, ub, wide;
    longint          sa, sb, sr;
    int              n;
    ua = 64'(a); ub = 64'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    n  = int'(b[4:0]);
    r = 32'd0; c = 1'b0; v = 1'b0;
    case (sel)
      ALU_ADD: begin
        wide = ua + ub; r = wide[31:0]; c = (wide >= 64'h1_0000_0000);
        sr = sa + sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      ALU_SUB: begin
        r = 32'(ua - ub); c = (ua >= ub);
        sr = sa - sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      ALU_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (ua < ub) ? 32'd1 : 32'd0;
      ALU_XOR:  r = a ^ b;
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      ALU_PASS: r = b;
      ALU_SLL:  r = a << n;
      ALU_SRL:  r = a >> n;
      ALU_SRA, ALU_SRAI: r = 32'(sa >>> n);
      default:  r = 32'd0;
    endcase
  endfunction

  // Present one operation from IDLE/DONE, wait for its result and check it.
  task automatic do_op(input string tag, input logic [3:0] sel, input logic [31:0] a,
                       input logic [31:0] b);
    logic [31:0] er;
    logic        ec, ev;
    int          n, lat, cycles;
    model(sel, a, b, er, ec, ev);
    n   = int'(b[4:0]);
    lat = (is_shift_op(sel) && n > 0) ? 1 + (n + STEP - 1) / STEP : 1;
    in_valid = 1'b1; alu_sel = sel; op_a = a; op_b = b; out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom; alu_sel = 4'($urandom);
    cycles = 1;
    while (!out_valid && cycles < 64) begin
      if (busy !== 1'b1) chk({tag, "_busy"}, 32'(busy), 32'd1);
      tick();
      cycles++;
    end
    chk({tag, "_latency"}, 32'(cycles), 32'(lat));
    chk({tag, "_result"}, result, er);
    chk({tag, "_flags"}, {28'd0, flag_z, flag_c, flag_v, flag_s},
        {28'd0, (er == 32'd0), ec, ev, er[31]});
  endtask

  initial begin
    logic [3:0]  rsel;
    logic [31:0] ra, rb, held;

    rst = 1'b0; in_valid = 1'b0; alu_sel = '0; op_a = '0; op_b = '0; out_ready = 1'b0;

    // Reset held for two edges.
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {28'd0, flag_z, flag_c, flag_v, flag_s}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready_low", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_out_valid", 32'(out_valid), 32'd0);

    // Directed cases.
    do_op("sub_eq", ALU_SUB, 32'd5, 32'd5);
    do_op("sub_ovf", ALU_SUB, 32'h8000_0000, 32'd1);
    do_op("sltu", ALU_SLTU, 32'd1, 32'hFFFF_FFFF);
    do_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    do_op("add_carry", ALU_ADD, 32'hFFFF_FFFF, 32'd1);
    do_op("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'd1);
    do_op("undef", 4'd13, 32'h1234_5678, 32'h9ABC_DEF0);
    do_op("sra31", ALU_SRA, 32'h8000_0000, 32'd31);
    do_op("srai", ALU_SRAI, 32'h8000_00F0, 32'd5);
    do_op("srl_zero", ALU_SRL, 32'hDEAD_BEEF, 32'd0);
    do_op("sll4", ALU_SLL, 32'd1, 32'd4);

    // Back-pressure: hold result for three cycles while a new op is offered.
    out_ready = 1'b0;
    held = result;
    in_valid = 1'b1; alu_sel = ALU_ADD; op_a = 32'd7; op_b = 32'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("bp_result", result, held);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1; alu_sel = ALU_PASS; op_a = 32'd0; op_b = 32'h1234_5000;
    #1;
    chk("bp_accept_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_pass_result", result, 32'h1234_5000);
    chk("bp_pass_valid", 32'(out_valid), 32'd1);

    // Randomized operations.
    for (int i = 0; i < 150; i++) begin
      rsel = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if ($urandom_range(0, 3) == 0) ra = {ra[31], 31'd0};
      do_op("rand", rsel, ra, rb);
    end

    // Reset in the middle of a shift aborts it.
    in_valid = 1'b1; alu_sel = ALU_SRL; op_a = 32'hFFFF_FFFF; op_b = 32'd31; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    tick();
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_busy_clr", 32'(busy), 32'd0);
    chk("mid_result", result, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b0) chk("mid_no_output", 32'(out_valid), 32'd0);
    end
    chk("mid_idle_ready", 32'(in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute-stage ALU that consumes the 4-bit `ALU_selection` code from the ALU control unit, together with two 32-bit operands, and returns a result plus branch flags under a valid/ready handshake. Logic, arithmetic and compare operations complete in one cycle. Shifts run on an iterative shifter at a parameterised number of bit positions per cycle. The block sits between the decode/ALU-control logic and the branch-resolution and writeback logic.

## Interface
Parameters:
- `SHIFT_STEP`, default 1: maximum shift distance applied per cycle. Legal values are 1, 2, 4, 8, 16 and 32. The value 32 makes every shift single-pass.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `in_valid` in 1: operation presented.
- `in_ready` out 1: block can accept an operation this cycle.
- `alu_sel` in 4: operation code, using the `ALU_*` macros in defines.v (`ALU_ADD`, `ALU_SUB`, `ALU_SLL`, `ALU_SLT`, `ALU_SLTU`, `ALU_XOR`, `ALU_SRL`, `ALU_SRA`, `ALU_SRAI`, `ALU_OR`, `ALU_AND`, `ALU_PASS`).
- `op_a` in 32: first operand.
- `op_b` in 32: second operand; bits [4:0] are the shift amount.
- `out_valid` out 1: `result` and the flags are valid.
- `out_ready` in 1: consumer takes the result this cycle.
- `result` out 32: registered result.
- `flag_z` out 1: result equals zero.
- `flag_c` out 1: carry out (ADD) or no-borrow (SUB).
- `flag_v` out 1: signed overflow (ADD/SUB).
- `flag_s` out 1: `result[31]`.
- `busy` out 1: iterative shift in progress.

## Operation
- **FSM states:**
  - IDLE: no result held.
  - SHIFT: iterating a shift.
  - DONE: result held, `out_valid=1`.
- **`in_ready` rule:** `in_ready = rst & ((state==IDLE) | (state==DONE & out_ready))`. An operation is accepted when `in_valid & in_ready`.
- **Non-shift op accepted:** the result is computed from the inputs and registered; the next state is DONE.
- **Shift op accepted** (`ALU_SLL`, `ALU_SRL`, `ALU_SRA`, `ALU_SRAI`):
  - Load the internal value register with `op_a`, the remaining-amount register with `op_b[4:0]`, and latch the shift kind.
  - If the amount is 0, the next state is DONE with `result=op_a`. Otherwise the next state is SHIFT.
- **SHIFT state:** each cycle, shift by `k = min(remaining, SHIFT_STEP)` and set `remaining -= k`. When `remaining` reaches 0, write the value into `result` and go to DONE.
  - SRL fills with zeros.
  - SRA and SRAI are identical: both fill with the latched `op_a[31]`.
- **DONE state:**
  - If `out_ready` is high and no new operation is accepted, go to IDLE.
  - If `out_ready` is high and a new operation is accepted in the same cycle, load it. Throughput is one op per cycle for non-shift ops.
  - If `out_ready` is low, hold `result`, the flags and `out_valid` unchanged.
- **Arithmetic** (all 32-bit, modulo 2^32):
  - ADD: `op_a+op_b`; `flag_c` is bit 32 of the 33-bit sum.
  - SUB: `op_a+~op_b+1`; `flag_c` is bit 32 of that sum, so 1 means `op_a >= op_b` unsigned.
  - `flag_v` for ADD and SUB is signed overflow: operand signs match (for SUB, `op_a` and `~op_b`) and the result sign differs.
  - SLT: signed compare, result 1 or 0. SLTU: unsigned compare, result 1 or 0.
  - XOR, OR, AND: bitwise.
  - PASS: `result=op_b`.
- **Flags on other ops:** `flag_c=flag_v=0` for all operations other than ADD and SUB. `flag_z` and `flag_s` are always derived from the final `result`.
- **Undefined `alu_sel` code:** `result=0`, `flag_z=1`, all other flags 0, single-cycle.
- **`busy`:** equals `(state==SHIFT)`.

## Timing
- **Reset** (`rst` low at an edge):
  - `state=IDLE`, `out_valid=0`, `result=0`, all flags 0, `busy=0`.
  - `in_ready` is 0 while `rst` is low.
  - A shift in progress is aborted and no output is produced for it.
- **Non-shift op** accepted at edge T: `out_valid=1` from T+1.
- **Shift by n** accepted at edge T:
  - n=0: `out_valid=1` from T+1.
  - n>0: `busy=1` from T+1 to T+ceil(n/SHIFT_STEP); `out_valid=1` from T+1+ceil(n/SHIFT_STEP).
- **Inputs during SHIFT:** `in_ready=0`; `in_valid`, `alu_sel` and operands are ignored.
- **Hold stability:** while `out_valid=1` and `out_ready=0`, all outputs are held stable regardless of `in_valid` or other inputs.

## Test plan
- **Reset:** drive `rst=0` for 2 cycles, then release -> `out_valid=0`, `result=0`, flags 0, `in_ready=1` on the first cycle after release.
- **SUB equal operands:** `ALU_SUB`, `op_a=5`, `op_b=5` -> next cycle `result=0`, `z=1`, `c=1`, `v=0`, `s=0`.
- **SUB overflow:** `ALU_SUB`, `op_a=0x80000000`, `op_b=1` -> `result=0x7FFFFFFF`, `v=1`, `c=1`.
- **SLTU:** `ALU_SLTU`, `op_a=1`, `op_b=0xFFFFFFFF` -> `result=1`.
- **Arithmetic shift, SHIFT_STEP=1:** `ALU_SRA`, `op_a=0x80000000`, `op_b=31` -> `busy` for 31 cycles; `out_valid` at T+32; `result=0xFFFFFFFF`.
- **Back-pressure and throughput:** `ALU_SLL`, `op_a=1`, `op_b=4` with `SHIFT_STEP=4` -> `result=0x10` at T+2. Hold `out_ready=0` for 3 cycles -> result stable, `in_ready=0`. Then `out_ready=1` with `ALU_PASS`, `op_b=0x12345000` accepted in the same cycle -> `result=0x12345000` on the next cycle.
- **Reset mid-operation:** assert reset mid-shift -> next cycle `out_valid=0`, `busy=0`, `result=0`.
